rr_mux8_arbiter: RTL and testbench
==================================

Name: rr_mux8_arbiter

Overview:
- Round-robin scheduler that shares the existing 8-to-1 single-bit mux between eight requesters.
- Accepts per-requester request lines and generates the mux select and a one-hot grant.
- Gates the muxed output with a valid flag.
- Sits directly in front of mux_8x1, which it instantiates, and replaces the free-running select counter the team currently uses to exercise that mux.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one requester may keep the grant (legal range 1..15).
- HOLD_W, 4: width of the hold counter; must satisfy 2**HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request lines; req[k] high means requester k wants the mux.
- din  input  8  data bits; din[k] belongs to requester k and feeds mux input i<k>.
- gnt  output  8  one-hot grant, registered; all zeros when nothing is granted.
- sel  output  3  mux select, registered; the index of the granted requester.
- gnt_valid  output  1  high while a grant is active (equals |gnt).
- dout  output  1  mux output gated by gnt_valid; 0 when gnt_valid=0.

Behaviour:
- Reset (asynchronous, rst_n=0), applied immediately:
  - gnt=0, sel=0, gnt_valid=0, dout=0.
  - state=IDLE, priority pointer ptr=0, hold_cnt=0.
  - Reset asserted mid-grant drops the grant in the same instant; no completion cycle.
- States: IDLE and GRANT.
- Winner search: circular scan of req starting at ptr, ascending, wrapping 7->0. The first asserted bit wins. A requester equal to ptr-1 is scanned last.
- IDLE:
  - If req != 0 at a rising edge: winner w is registered (gnt=1<<w, sel=w, gnt_valid=1, hold_cnt=0) and state moves to GRANT.
  - Latency is one clock from req sampled to gnt visible.
  - If req == 0: remain in IDLE with outputs at reset values. ptr is unchanged.
- GRANT, at each rising edge with granted index g=sel:
  - Continue if req[g]=1 and hold_cnt < MAX_HOLD-1: hold_cnt increments; gnt and sel are unchanged.
  - Release if req[g]=0 or hold_cnt == MAX_HOLD-1:
    - ptr <= g+1 (mod 8; 7 wraps to 0).
    - The winner search runs in the same edge using the new pointer value g+1. This gives back-to-back grants with no idle cycle.
    - If a winner exists: the new gnt and sel are registered and hold_cnt=0.
    - If no winner exists: go to IDLE and clear gnt, sel and gnt_valid.
  - If the releasing requester is the only one still requesting (MAX_HOLD expiry), it is re-granted on the next cycle with hold_cnt=0.
- MAX_HOLD=1: the grant re-arbitrates every cycle, giving pure round-robin rotation.
- dout: combinational from the mux_8x1 instance (din, sel), ANDed with gnt_valid. No additional latency.
- sel changes only at clock edges, so dout is glitch-free with respect to sel.
- Request changes between edges have no effect until the next rising edge. There are no asynchronous paths from req to the outputs.
- gnt is always one-hot or zero; two bits are never set.

Decomposition:
- Shared package/header holds:
  - NUM_REQ=8, SEL_W=3.
  - State encodings: IDLE=1'b0, GRANT=1'b1.
  - A "priority scan" function: an 8-bit request plus a 3-bit pointer in, a 3-bit index plus a found flag out.
- One sub-module: reuse the existing mux_8x1 (built from three 4x1 muxes) for the datapath.
- The arbiter FSM, pointer and hold counter stay in rr_mux8_arbiter.

Test Plan:
- Reset then idle: rst_n low for 2 cycles with req=8'h00 -> gnt=0, sel=0, gnt_valid=0, dout=0; after release, outputs stay 0 for 5 cycles.
- Single requester hold limit (MAX_HOLD=4): req=8'h08, din=8'h08 -> one cycle later gnt=8'h08, sel=3, dout=1.
  - The grant holds 4 cycles, then re-grants to requester 3 with hold_cnt reset.
  - gnt_valid never drops.
- Round-robin fairness: req=8'hFF held, din=8'hAA -> sel sequence 0,1,2,...,7,0, each for 4 cycles; dout alternates 0,1 per grant.
- Early release and skip: grant on 2, req changes to 8'h81 -> next edge gnt=8'h80 (sel=7); after it drops, gnt=8'h01 (wrap to 0).
- Async reset mid-grant: during a grant on 5, pull rst_n low between edges -> gnt, sel, gnt_valid and dout go 0 immediately.
  - After release with req=8'hFF, the first grant is to requester 0 (ptr reset).
- Data gating: req=0, din=8'hFF -> dout=0; then req=8'h40 -> after one edge, sel=6 and dout=1.

Source files
------------

// File: rtl/rr_mux8_arbiter_pkg.sv
// Shared types and helpers for the round-robin 8:1 mux arbiter.
package rr_mux8_arbiter_pkg;
  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } scan_t;

  // Circular scan from ptr upward; descending loop so the lowest offset wins last.
  function automatic scan_t prio_scan(input logic [NUM_REQ-1:0] req,
                                      input logic [SEL_W-1:0]   ptr);
    scan_t            r;
    logic [SEL_W-1:0] k;
    r = '0;
    for (int i = NUM_REQ-1; i >= 0; i--) begin
      k = ptr + SEL_W'(i);
      if (req[k]) begin
        r.found = 1'b1;
        r.idx   = k;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/rr_mux8_arbiter_if.sv
// Request/grant/data bundle between requesters and the arbiter.
interface rr_mux8_arbiter_if;
  import rr_mux8_arbiter_pkg::*;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] din;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               gnt_valid;
  logic               dout;

  modport master (output req, din, input  gnt, sel, gnt_valid, dout);
  modport slave  (input  req, din, output gnt, sel, gnt_valid, dout);
endinterface

// File: rtl/rr_mux8_arbiter_mux.sv
// Existing single-bit 8:1 mux, built from three 4:1 muxes.
module mux_4x1 (
  input  logic       i0, i1, i2, i3,
  input  logic [1:0] s,
  output logic       y
);
  assign y = s[1] ? (s[0] ? i3 : i2) : (s[0] ? i1 : i0);
endmodule

module mux_8x1 (
  input  logic       i0, i1, i2, i3, i4, i5, i6, i7,
  input  logic [2:0] sel,
  output logic       y
);
  logic lo, hi;

  mux_4x1 u_lo  (.i0(i0), .i1(i1), .i2(i2), .i3(i3), .s(sel[1:0]), .y(lo));
  mux_4x1 u_hi  (.i0(i4), .i1(i5), .i2(i6), .i3(i7), .s(sel[1:0]), .y(hi));
  mux_4x1 u_top (.i0(lo), .i1(hi), .i2(1'b0), .i3(1'b0), .s({1'b0, sel[2]}), .y(y));
endmodule

// File: rtl/rr_mux8_arbiter.sv
// Round-robin arbiter sharing mux_8x1 among eight requesters, with a
// per-grant hold limit and a valid-gated data output.
module rr_mux8_arbiter
  import rr_mux8_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_mux8_arbiter_if.slave  bus
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   scan_ptr;
  logic               rearb;
  scan_t              scan;
  logic               mux_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    hold_d   = hold_q;
    gnt_d    = gnt_q;
    scan_ptr = ptr_q;
    rearb    = 1'b0;

    case (state_q)
      IDLE: rearb = 1'b1;
      GRANT: begin
        if (bus.req[sel_q] && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          // Release: the new pointer is used for the scan in this same edge.
          rearb    = 1'b1;
          ptr_d    = sel_q + SEL_W'(1);
          scan_ptr = sel_q + SEL_W'(1);
        end
      end
      default: rearb = 1'b1;
    endcase

    scan = prio_scan(bus.req, scan_ptr);

    if (rearb) begin
      hold_d = '0;
      if (scan.found) begin
        state_d = GRANT;
        sel_d   = scan.idx;
        gnt_d   = NUM_REQ'(1) << scan.idx;
      end else begin
        state_d = IDLE;
        sel_d   = '0;
        gnt_d   = '0;
      end
    end
  end

  mux_8x1 u_mux (
    .i0 (bus.din[0]), .i1 (bus.din[1]), .i2 (bus.din[2]), .i3 (bus.din[3]),
    .i4 (bus.din[4]), .i5 (bus.din[5]), .i6 (bus.din[6]), .i7 (bus.din[7]),
    .sel(sel_q),
    .y  (mux_y)
  );

  assign bus.gnt       = gnt_q;
  assign bus.sel       = sel_q;
  assign bus.gnt_valid = |gnt_q;
  assign bus.dout      = mux_y & (|gnt_q);
endmodule

// File: tb/tb_rr_mux8_arbiter.sv
// Bench for rr_mux8_arbiter: owner/tenure model checked every cycle plus directed cases.
module tb_rr_mux8_arbiter;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_mux8_arbiter_if bus ();

  rr_mux8_arbiter #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // First requester at or after start, wrapping; -1 if none.
  function automatic int pick(input logic [7:0] r, input int start);
    for (int o = 0; o < 8; o++)
      if (r[(start + o) % 8]) return (start + o) % 8;
    return -1;
  endfunction

  // Model: who owns the mux, how many cycles it has held it, where the next scan starts.
  int m_own, m_ten, m_ptr;
  always @(posedge clk or negedge rst_n) begin
    int st, w;
    if (!rst_n) begin
      m_own <= -1;
      m_ten <= 0;
      m_ptr <= 0;
    end else if (m_own >= 0 && bus.req[m_own] && m_ten < MAX_HOLD) begin
      m_ten <= m_ten + 1;
    end else begin
      st = (m_own >= 0) ? (m_own + 1) % 8 : m_ptr;
      w  = pick(bus.req, st);
      m_ptr <= st;
      m_own <= w;
      m_ten <= (w >= 0) ? 1 : 0;
    end
  end

  always @(negedge clk) begin
    logic [7:0] eg;
    logic [2:0] es;
    logic       ed;
    eg = (m_own >= 0) ? 8'(1 << m_own) : 8'h00;
    es = (m_own >= 0) ? m_own[2:0] : 3'd0;
    ed = (m_own >= 0) ? bus.din[m_own] : 1'b0;
    chk("model_gnt", bus.gnt, eg);
    chk("model_sel", bus.sel, es);
    chk("model_valid", bus.gnt_valid, (m_own >= 0));
    chk("model_dout", bus.dout, ed);
    chk("onehot0", $onehot0(bus.gnt), 1);
  end

  task automatic do_reset();
    @(posedge clk); #2;
    bus.req = '0;
    rst_n   = 1'b0;
    @(posedge clk); #2;
    rst_n   = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    bus.din = '0;

    chk("pick_wrap", pick(8'h81, 3), 7);
    chk("pick_self_last", pick(8'h04, 3), 2);
    chk("pick_none", pick(8'h00, 0), 32'hFFFF_FFFF);

    // Reset, then idle
    repeat (2) @(posedge clk); #2;
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_valid", bus.gnt_valid, 0);
    chk("rst_dout", bus.dout, 0);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_gnt", bus.gnt, 0);
    end

    // Single requester hits the hold limit and is re-granted
    @(posedge clk); #2;
    bus.req = 8'h08; bus.din = 8'h08;
    @(posedge clk); @(negedge clk);
    chk("single_gnt", bus.gnt, 8'h08);
    chk("single_sel", bus.sel, 3);
    chk("single_dout", bus.dout, 1);
    repeat (12) begin
      @(negedge clk);
      chk("single_valid", bus.gnt_valid, 1);
      chk("single_hold_gnt", bus.gnt, 8'h08);
    end

    // Round-robin fairness, 4 cycles per grant
    do_reset();
    bus.req = 8'hFF; bus.din = 8'hAA;
    @(posedge clk);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      chk("rr_sel", bus.sel, (i / 4) % 8);
      chk("rr_dout", bus.dout, (i / 4) % 2);
    end

    // Early release and skip with wrap
    do_reset();
    bus.req = 8'h04; bus.din = 8'h00;
    @(posedge clk); @(negedge clk);
    chk("early_first", bus.gnt, 8'h04);
    @(posedge clk); #2;
    bus.req = 8'h81;
    @(posedge clk); @(negedge clk);
    chk("early_skip_gnt", bus.gnt, 8'h80);
    chk("early_skip_sel", bus.sel, 7);
    @(posedge clk); #2;
    bus.req = 8'h01;
    @(posedge clk); @(negedge clk);
    chk("early_wrap_gnt", bus.gnt, 8'h01);
    chk("early_wrap_sel", bus.sel, 0);

    // Async reset mid-grant
    do_reset();
    bus.req = 8'h20; bus.din = 8'h20;
    @(posedge clk); @(negedge clk);
    chk("async_pre_gnt", bus.gnt, 8'h20);
    chk("async_pre_dout", bus.dout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", bus.gnt, 0);
    chk("async_sel", bus.sel, 0);
    chk("async_valid", bus.gnt_valid, 0);
    chk("async_dout", bus.dout, 0);
    bus.req = 8'hFF;
    #3 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("async_after_gnt", bus.gnt, 8'h01);
    chk("async_after_sel", bus.sel, 0);

    // Data gating
    @(posedge clk); #2;
    bus.req = 8'h00; bus.din = 8'hFF;
    @(posedge clk); @(negedge clk);
    chk("gate_dout", bus.dout, 0);
    chk("gate_valid", bus.gnt_valid, 0);
    @(posedge clk); #2;
    bus.req = 8'h40;
    @(posedge clk); @(negedge clk);
    chk("gate_sel", bus.sel, 6);
    chk("gate_dout_on", bus.dout, 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
